// File: rtl/vin_tc_pkg.sv
// Shared types and helpers for the vin thermocouple readers: FSM states, converter
// modes, frame length and raw-word decode into {fault, quarter-degree temperature}.
package vin_tc_pkg;

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_SELECT,
      ST_SHIFT_HI,
      ST_SHIFT_LO,
      ST_DESELECT,
      ST_PUBLISH
   } tc_state_e;

   localparam int MODE_MAX6675  = 0;
   localparam int MODE_MAX31855 = 1;

   function automatic int frame_bits(input int mode);
      return (mode == MODE_MAX31855) ? 32 : 16;
   endfunction

   // MAX6675 reports an unsigned 12-bit value; MAX31855 a signed 14-bit one.
   function automatic logic [16:0] tc_decode(input int mode, input logic [31:0] word);
      logic [16:0] r;
      if (mode == MODE_MAX31855) begin
         r = {word[16], {2{word[31]}}, word[31:18]};
      end else begin
         r = {word[2], 4'b0000, word[14:3]};
      end
      return r;
   endfunction

endpackage

// File: rtl/vin_tc_tick.sv
// Divider producing a one-cycle tick every DIVIDER clk cycles; first tick right after reset.
// Free-running, no backpressure.
module vin_tc_tick #(
   parameter int DIVIDER = 1000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);
   localparam int            CW     = $clog2(DIVIDER);
   localparam logic [CW-1:0] RELOAD = CW'(DIVIDER - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
         cnt_d = RELOAD;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/vin_tc_spi_multi.sv
// Round-robin reader for CHANNELS thermocouple converters on one shared SCLK/MISO.
// Each frame: INTERVAL idle ticks, 2N+2 frame ticks, then a one-cycle publish; no backpressure.
module vin_tc_spi_multi
   import vin_tc_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int DIVIDER  = 1000,
   parameter int MODE     = 0,
   parameter int INTERVAL = 100000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   spi_miso,
   output logic                   spi_sclk,
   output logic [CHANNELS-1:0]    spi_cs,
   output logic [16*CHANNELS-1:0] temperature,
   output logic [CHANNELS-1:0]    fault,
   output logic [CHANNELS-1:0]    valid,
   output logic                   sample_strobe,
   output logic [3:0]             sample_ch
);
   localparam int          N        = frame_bits(MODE);
   localparam logic [5:0]  BIT_LAST = 6'(N - 1);
   localparam logic [31:0] INT_LAST = (INTERVAL > 0) ? 32'(INTERVAL - 1) : 32'd0;
   localparam logic [3:0]  CH_LAST  = 4'(CHANNELS - 1);

   tc_state_e              state_q, state_d;
   logic [31:0]            int_cnt_q, int_cnt_d;
   logic [5:0]             bit_cnt_q, bit_cnt_d;
   logic [3:0]             ch_q, ch_d;
   logic [31:0]            shreg_q, shreg_d;
   logic [CHANNELS-1:0]    cs_q, cs_d;
   logic                   sclk_q, sclk_d;
   logic [16*CHANNELS-1:0] temp_q, temp_d;
   logic [CHANNELS-1:0]    fault_q, fault_d;
   logic [CHANNELS-1:0]    valid_q, valid_d;
   logic                   strobe_q, strobe_d;
   logic [3:0]             sample_ch_q, sample_ch_d;
   logic                   miso_q;
   logic                   tick;
   logic [16:0]            decoded;

   vin_tc_tick #(.DIVIDER(DIVIDER)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign decoded = tc_decode(MODE, shreg_q);

   always_comb begin
      state_d     = state_q;
      int_cnt_d   = int_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      ch_d        = ch_q;
      shreg_d     = shreg_q;
      cs_d        = cs_q;
      sclk_d      = sclk_q;
      temp_d      = temp_q;
      fault_d     = fault_q;
      valid_d     = valid_q;
      strobe_d    = 1'b0;
      sample_ch_d = sample_ch_q;
      case (state_q)
         ST_WAIT: if (tick) begin
            if (int_cnt_q >= INT_LAST) begin
               // CS drops on entry to SELECT so a full tick separates it from the first SCLK rise.
               int_cnt_d = '0;
               bit_cnt_d = '0;
               shreg_d   = '0;
               sclk_d    = 1'b0;
               for (int k = 0; k < CHANNELS; k++) begin
                  cs_d[k] = (ch_q != 4'(k));
               end
               state_d = ST_SELECT;
            end else begin
               int_cnt_d = int_cnt_q + 32'd1;
            end
         end
         ST_SELECT: if (tick) begin
            state_d = ST_SHIFT_HI;
         end
         ST_SHIFT_HI: if (tick) begin
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[30:0], miso_q};
            state_d = ST_SHIFT_LO;
         end
         ST_SHIFT_LO: if (tick) begin
            sclk_d = 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
               state_d = ST_DESELECT;
            end else begin
               bit_cnt_d = bit_cnt_q + 6'd1;
               state_d   = ST_SHIFT_HI;
            end
         end
         ST_DESELECT: if (tick) begin
            cs_d    = '1;
            state_d = ST_PUBLISH;
         end
         ST_PUBLISH: begin
            for (int k = 0; k < CHANNELS; k++) begin
               if (ch_q == 4'(k)) begin
                  temp_d[16*k +: 16] = decoded[15:0];
                  fault_d[k]         = decoded[16];
                  valid_d[k]         = 1'b1;
               end
            end
            strobe_d    = 1'b1;
            sample_ch_d = ch_q;
            ch_d        = (ch_q == CH_LAST) ? 4'd0 : ch_q + 4'd1;
            state_d     = ST_WAIT;
         end
         default: state_d = ST_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_WAIT;
         int_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         ch_q        <= '0;
         shreg_q     <= '0;
         cs_q        <= '1;
         sclk_q      <= 1'b0;
         temp_q      <= '0;
         fault_q     <= '0;
         valid_q     <= '0;
         strobe_q    <= 1'b0;
         sample_ch_q <= '0;
         miso_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         int_cnt_q   <= int_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         ch_q        <= ch_d;
         shreg_q     <= shreg_d;
         cs_q        <= cs_d;
         sclk_q      <= sclk_d;
         temp_q      <= temp_d;
         fault_q     <= fault_d;
         valid_q     <= valid_d;
         strobe_q    <= strobe_d;
         sample_ch_q <= sample_ch_d;
         miso_q      <= spi_miso;
      end
   end

   assign spi_sclk      = sclk_q;
   assign spi_cs        = cs_q;
   assign temperature   = temp_q;
   assign fault         = fault_q;
   assign valid         = valid_q;
   assign sample_strobe = strobe_q;
   assign sample_ch     = sample_ch_q;

endmodule

// File: tb/tb_vin_tc_spi_multi.sv
// Bench for vin_tc_spi_multi: a 3-channel MAX6675 instance and a 1-channel MAX31855
// instance, each driven by a small converter model, with frame-timing monitoring.
module tb_vin_tc_spi_multi;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        miso0 = 1'b0;
   logic        sclk0;
   logic [2:0]  cs0;
   logic [47:0] temp0;
   logic [2:0]  fault0, valid0;
   logic        stb0;
   logic [3:0]  sch0;

   logic        miso1 = 1'b0;
   logic        sclk1;
   logic [0:0]  cs1;
   logic [15:0] temp1;
   logic [0:0]  fault1, valid1;
   logic        stb1;
   logic [3:0]  sch1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vin_tc_spi_multi #(.CHANNELS(3), .DIVIDER(2), .MODE(0), .INTERVAL(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .spi_miso(miso0), .spi_sclk(sclk0), .spi_cs(cs0),
      .temperature(temp0), .fault(fault0), .valid(valid0),
      .sample_strobe(stb0), .sample_ch(sch0)
   );

   vin_tc_spi_multi #(.CHANNELS(1), .DIVIDER(2), .MODE(1), .INTERVAL(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .spi_miso(miso1), .spi_sclk(sclk1), .spi_cs(cs1),
      .temperature(temp1), .fault(fault1), .valid(valid1),
      .sample_strobe(stb1), .sample_ch(sch1)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Converter models and frame monitor for instance 0.
   logic [15:0] mem0 [3];
   logic [15:0] sh0;
   logic [2:0]  prev_cs0 = 3'b111;
   logic        prev_sclk0 = 1'b0;
   int          nlow, cur_idx, last_cs_idx = -1;
   int          rises, sclk_edges, win_len, gap_len, multi_low = 0;
   bit          win_active = 0, seen_window = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         win_active  = 0;
         seen_window = 0;
         gap_len     = 0;
         sclk_edges  = 0;
         prev_cs0    = 3'b111;
         prev_sclk0  = 1'b0;
         miso0       = 1'b0;
      end else begin
         nlow    = 0;
         cur_idx = 0;
         for (int k = 0; k < 3; k++) begin
            if (!cs0[k]) begin
               nlow++;
               cur_idx = k;
            end
         end
         if (nlow > 1) multi_low++;
         if (prev_cs0 == 3'b111 && nlow == 1) begin
            if (seen_window) chk("gap_clk", gap_len, 8);
            last_cs_idx = cur_idx;
            sh0         = mem0[cur_idx];
            miso0       = sh0[15];
            rises       = 0;
            sclk_edges  = 0;
            win_len     = 0;
            win_active  = 1;
         end
         if (win_active && prev_sclk0 && !sclk0) begin
            sh0        = sh0 << 1;
            miso0      = sh0[15];
            sclk_edges++;
         end
         if (nlow >= 1) begin
            win_len++;
            if (!prev_sclk0 && sclk0) begin
               rises++;
               sclk_edges++;
            end
         end
         if (nlow == 0 && win_active) begin
            chk("sclk_rises", rises, 16);
            chk("cs_low_clk", win_len, 68);
            win_active  = 0;
            seen_window = 1;
            gap_len     = 0;
         end
         if (nlow == 0) gap_len++;
         prev_cs0   = cs0;
         prev_sclk0 = sclk0;
      end
   end

   logic [31:0] mem1, sh1;
   logic        prev_cs1 = 1'b1, prev_sclk1 = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_cs1   = 1'b1;
         prev_sclk1 = 1'b0;
         miso1      = 1'b0;
      end else begin
         if (prev_cs1 && !cs1[0]) begin
            sh1   = mem1;
            miso1 = sh1[31];
         end else if (prev_sclk1 && !sclk1) begin
            sh1   = sh1 << 1;
            miso1 = sh1[31];
         end
         prev_cs1   = cs1[0];
         prev_sclk1 = sclk1;
      end
   end

   task automatic wait_strobe(input int which, input int limit, output bit ok);
      ok = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if ((which == 0 && stb0) || (which == 1 && stb1)) begin
            ok = 1;
            return;
         end
      end
   endtask

   logic [15:0] exp_t [4] = '{16'h0190, 16'h0000, 16'h03E3, 16'h0FFF};
   logic        exp_f [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   logic [47:0] exp_bus;
   logic [2:0]  exp_fault, exp_valid;

   initial begin
      bit ok0, ok1, okr, hit;
      int exp_ch;
      mem0[0] = 16'h0C80;
      mem0[1] = 16'h0004;
      mem0[2] = 16'h1F18;
      mem1    = 32'hFF9C0000;
      exp_bus   = '0;
      exp_fault = '0;
      exp_valid = '0;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cs0", cs0, 3'b111);
      chk("rst_sclk0", sclk0, 0);
      chk("rst_temp0", temp0, 0);
      chk("rst_fault0", fault0, 0);
      chk("rst_valid0", valid0, 0);
      chk("rst_stb0", stb0, 0);
      chk("rst_sch0", sch0, 0);
      chk("rst_cs1", cs1, 1);
      rst_n = 1'b1;

      fork
         begin
            for (int i = 0; i < 4; i++) begin
               wait_strobe(0, 200, ok0);
               chk("stb0_seen", ok0, 1);
               if (!ok0) break;
               exp_ch = i % 3;
               exp_bus[16*exp_ch +: 16] = exp_t[i];
               exp_fault[exp_ch] = exp_f[i];
               exp_valid[exp_ch] = 1'b1;
               chk("sample_ch0", sch0, exp_ch);
               chk("cs_order", last_cs_idx, exp_ch);
               chk("temp_bus0", temp0, exp_bus);
               chk("fault0", fault0, exp_fault);
               chk("valid0", valid0, exp_valid);
               if (i == 0) mem0[0] = 16'h7FF8;
               @(negedge clk);
               chk("stb0_single", stb0, 0);
            end
         end
         begin
            wait_strobe(1, 400, ok1);
            chk("stb1_seen_a", ok1, 1);
            chk("temp1_neg", temp1, 16'hFFE7);
            chk("fault1_a", fault1, 0);
            chk("valid1", valid1, 1);
            chk("sample_ch1", sch1, 0);
            mem1 = 32'h00010001;
            wait_strobe(1, 400, ok1);
            chk("stb1_seen_b", ok1, 1);
            chk("temp1_fault", temp1, 16'h0000);
            chk("fault1_b", fault1, 1);
         end
      join

      // Reset in the middle of the next (channel 1) frame.
      hit = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (win_active && sclk_edges >= 5) begin
            hit = 1;
            break;
         end
      end
      chk("midframe_reached", hit, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_cs0", cs0, 3'b111);
      chk("mid_rst_sclk0", sclk0, 0);
      chk("mid_rst_stb0", stb0, 0);
      chk("mid_rst_temp0", temp0, 0);
      chk("mid_rst_valid0", valid0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_strobe(0, 200, okr);
      chk("post_rst_stb0", okr, 1);
      chk("post_rst_sch0", sch0, 0);
      chk("post_rst_cs_idx", last_cs_idx, 0);
      chk("post_rst_temp0", temp0, 48'h0000_0000_0FFF);
      chk("post_rst_valid0", valid0, 3'b001);

      chk("multi_cs_low", multi_low, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
